// File: rtl/pwm_bank_controller.sv
`default_nettype none
// ============================================================================
// Module   : pwm_bank_controller
// Purpose  : NUM_CH active-low PWM channels sharing one 16-bit period counter,
//            with shadow registers committed only on a period boundary.
//            Optional soft start (define PWM_SOFT_START_EN) ramps each
//            channel toward its new value by RAMP_STEP per period.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_bank_controller #(
  parameter int          NUM_CH      = 4,
  parameter int          ADDR_W      = 4,
  parameter logic [15:0] TOP_DEFAULT = 16'hFFFF,
  parameter logic [15:0] RAMP_STEP   = 16'd256
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [15:0]       wr_data,
  input  logic              update,
  output logic              busy,
  output logic              commit_done,
  output logic              period_start,
  output logic [NUM_CH-1:0] pwm_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1
`ifdef PWM_SOFT_START_EN
    ,
    RAMP  = 2'd2
`endif
  } state_t;

  localparam logic [ADDR_W-1:0] c_top_addr = ADDR_W'(NUM_CH);

  // Move cur toward tgt by at most RAMP_STEP, landing exactly on tgt.
  function automatic logic [15:0] f_ramp_step(input logic [15:0] cur, input logic [15:0] tgt);
    logic [15:0] v_res;
    if (tgt > cur) begin
      v_res = ((tgt - cur) > RAMP_STEP) ? (cur + RAMP_STEP) : tgt;
    end else begin
      v_res = ((cur - tgt) > RAMP_STEP) ? (cur - RAMP_STEP) : tgt;
    end
    return v_res;
  endfunction

  state_t            r_state;
  logic [15:0]       r_count;
  logic [15:0]       r_top;
  logic [15:0]       r_top_shadow;
  logic [15:0]       r_shadow [NUM_CH];
  logic [15:0]       r_active [NUM_CH];
  logic [NUM_CH-1:0] r_pwm_out;
  logic              r_commit_done;
  logic              r_period_start;

  logic [15:0]       w_next_active [NUM_CH];
  logic [NUM_CH-1:0] w_pwm_next;
  logic              w_wrap;
  logic              w_wr_fire;
  logic              w_commit;

  assign w_wrap    = (r_count == r_top);
  assign wr_ready  = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign w_wr_fire = wr_valid && wr_ready;
  // Every non-IDLE state updates the active set on a wrap edge.
  assign w_commit  = w_wrap && (r_state != IDLE);

  assign pwm_out      = r_pwm_out;
  assign commit_done  = r_commit_done;
  assign period_start = r_period_start;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
`ifdef PWM_SOFT_START_EN
      w_next_active[i] = f_ramp_step(r_active[i], r_shadow[i]);
`else
      w_next_active[i] = r_shadow[i];
`endif
      w_pwm_next[i] = ~(r_count < r_active[i]);
    end
  end

`ifdef PWM_SOFT_START_EN
  logic w_ramp_done;

  always_comb begin
    w_ramp_done = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_next_active[i] != r_shadow[i]) begin
        w_ramp_done = 1'b0;
      end
    end
  end
`endif

  // Channel shadow and active compare registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_wr_fire && (wr_addr == ADDR_W'(i))) begin
          r_shadow[i] <= wr_data;
        end
        if (w_commit) begin
          r_active[i] <= w_next_active[i];
        end
      end
    end
  end

  // Period counter, outputs and commit sequencing.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_count        <= '0;
      r_top          <= TOP_DEFAULT;
      r_top_shadow   <= TOP_DEFAULT;
      r_state        <= IDLE;
      r_pwm_out      <= '1;
      r_commit_done  <= 1'b0;
      r_period_start <= 1'b0;
    end else begin
      r_count        <= w_wrap ? 16'd0 : (r_count + 16'd1);
      r_period_start <= w_wrap;
      r_pwm_out      <= w_pwm_next;
      r_commit_done  <= 1'b0;
      if (w_wr_fire && (wr_addr == c_top_addr)) begin
        r_top_shadow <= wr_data;
      end
      case (r_state)
        IDLE: begin
          if (update) begin
            r_state <= ARMED;
          end
        end
        ARMED: begin
          if (w_wrap) begin
            r_top <= r_top_shadow;
`ifdef PWM_SOFT_START_EN
            if (w_ramp_done) begin
              r_state       <= IDLE;
              r_commit_done <= 1'b1;
            end else begin
              r_state <= RAMP;
            end
`else
            r_state       <= IDLE;
            r_commit_done <= 1'b1;
`endif
          end
        end
`ifdef PWM_SOFT_START_EN
        RAMP: begin
          if (w_wrap && w_ramp_done) begin
            r_state       <= IDLE;
            r_commit_done <= 1'b1;
          end
        end
`endif
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pwm_bank_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_bank_controller
// Purpose  : Directed plus random checks of pwm_bank_controller against a
//            behavioural model of the period/commit rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_bank_controller;

  localparam int NUM_CH = 4;
  localparam int ADDR_W = 4;
  localparam int STEP   = 256;

  logic              clock    = 1'b0;
  logic              reset_n  = 1'b0;
  logic              wr_valid = 1'b0;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr  = '0;
  logic [15:0]       wr_data  = '0;
  logic              update   = 1'b0;
  logic              busy;
  logic              commit_done;
  logic              period_start;
  logic [NUM_CH-1:0] pwm_out;

  int n_checks = 0;
  int n_fail   = 0;

  pwm_bank_controller #(
    .NUM_CH      (NUM_CH),
    .ADDR_W      (ADDR_W),
    .TOP_DEFAULT (16'hFFFF),
    .RAMP_STEP   (16'd256)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .update       (update),
    .busy         (busy),
    .commit_done  (commit_done),
    .period_start (period_start),
    .pwm_out      (pwm_out)
  );

  always #5 clock = ~clock;

  // Behavioural model: plain integers, mode 0 idle / 1 waiting / 2 ramping.
  int                m_count, m_top, m_top_sh, m_mode;
  int                m_sh  [NUM_CH];
  int                m_act [NUM_CH];
  bit                m_ps, m_cd;
  logic [NUM_CH-1:0] m_pwm;

  function automatic int approach(input int cur, input int tgt);
`ifdef PWM_SOFT_START_EN
    int d;
    d = tgt - cur;
    if (d > STEP)  return cur + STEP;
    if (d < -STEP) return cur - STEP;
    return tgt;
`else
    return tgt + 0 * cur;
`endif
  endfunction

  function automatic void model_edge();
    bit wrap, ready, all_done;
    int a;
    if (!reset_n) begin
      m_count = 0; m_top = 65535; m_top_sh = 65535; m_mode = 0;
      foreach (m_sh[i]) begin m_sh[i] = 0; m_act[i] = 0; end
      m_pwm = '1; m_ps = 0; m_cd = 0;
      return;
    end
    wrap  = (m_count == m_top);
    ready = (m_mode == 0);
    for (int i = 0; i < NUM_CH; i++) m_pwm[i] = !(m_count < m_act[i]);
    m_ps = wrap;
    m_cd = 0;
    a = int'(wr_addr);
    if (wr_valid && ready) begin
      if (a < NUM_CH) m_sh[a] = int'(wr_data);
      else if (a == NUM_CH) m_top_sh = int'(wr_data);
    end
    if (ready) begin
      if (update) m_mode = 1;
    end else if (wrap) begin
      if (m_mode == 1) m_top = m_top_sh;
      all_done = 1;
      for (int i = 0; i < NUM_CH; i++) begin
        m_act[i] = approach(m_act[i], m_sh[i]);
        if (m_act[i] != m_sh[i]) all_done = 0;
      end
      if (all_done) begin m_mode = 0; m_cd = 1; end
      else m_mode = 2;
    end
    m_count = wrap ? 0 : m_count + 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    check("pwm_out", pwm_out, m_pwm);
    check("period_start", period_start, m_ps);
    check("commit_done", commit_done, m_cd);
    check("wr_ready", wr_ready, m_mode == 0);
    check("busy", busy, m_mode != 0);
  endtask

  task automatic write(input int addr, input int data);
    wr_valid = 1'b1; wr_addr = ADDR_W'(addr); wr_data = 16'(data);
    step();
    wr_valid = 1'b0;
  endtask

  task automatic pulse_update();
    update = 1'b1; step(); update = 1'b0;
  endtask

  task automatic wait_commit(input int budget);
    int n = 0;
    while (commit_done !== 1'b1 && n < budget) begin step(); n++; end
    check("commit_seen", commit_done, 1);
  endtask

  initial begin
    int n, lows, bad_ready, hi2, lo3, wraps, cds, r, a;

    // Reset and first period at the default top, with a commit armed meanwhile.
    reset_n = 1'b0;
    repeat (3) step();
    check("reset_pwm", pwm_out, 4'hF);
    check("reset_ready", wr_ready, 1);
    check("reset_busy", busy, 0);
    check("reset_pstart", period_start, 0);
    reset_n = 1'b1;
    n = 0;
    write(NUM_CH, 9); n++;
    write(0, 3);      n++;
    pulse_update();   n++;
    while (period_start !== 1'b1 && n < 70000) begin step(); n++; end
    check("first_period", n, 65536);
    check("first_commit", commit_done, 1);

    // Basic duty at top=9.
    lows = 0; n = 0;
    do begin
      step(); n++;
      if (pwm_out[0] === 1'b0) lows++;
    end while (period_start !== 1'b1 && n < 40);
    check("duty_period", n, 10);
    check("duty_ch0_lows", lows, 3);

    // Boundary safety: change ch1 mid-period.
    write(1, 2); pulse_update(); wait_commit(5000);
    lows = 0; bad_ready = 0;
    repeat (4) begin step(); if (pwm_out[1] === 1'b0) lows++; end
    wr_valid = 1'b1; wr_addr = 4'd1; wr_data = 16'd7; update = 1'b1;
    step();
    wr_valid = 1'b0; update = 1'b0;
    if (pwm_out[1] === 1'b0) lows++;
    n = 0;
    while (commit_done !== 1'b1 && n < 5000) begin
      if (wr_ready !== 1'b0) bad_ready++;
      step(); n++;
      if (pwm_out[1] === 1'b0) lows++;
    end
    check("boundary_commit", commit_done, 1);
    check("boundary_old_lows", lows, 2);
    check("boundary_ready_low", bad_ready, 0);
    lows = 0;
    repeat (10) begin step(); if (pwm_out[1] === 1'b0) lows++; end
    check("boundary_new_lows", lows, 7);

    // Extremes and a discarded out-of-range write.
    write(2, 0); write(3, 16'hFFFF); write(15, 16'h1234);
    pulse_update(); wait_commit(5000);
    hi2 = 0; lo3 = 0; wraps = 0;
    repeat (20) begin
      step();
      if (pwm_out[2] === 1'b1) hi2++;
      if (pwm_out[3] === 1'b0) lo3++;
      if (period_start === 1'b1) wraps++;
    end
    check("ch2_always_off", hi2, 20);
    check("ch3_always_on", lo3, 20);
    check("addr15_top_kept", wraps, 2);

    // Write in the same cycle as update.
    wr_valid = 1'b1; wr_addr = 4'd0; wr_data = 16'd5; update = 1'b1;
    step();
    wr_valid = 1'b0; update = 1'b0;
    wait_commit(5000);
    lows = 0;
    repeat (10) begin step(); if (pwm_out[0] === 1'b0) lows++; end
    check("same_cycle_write_lows", lows, 5);

    // update on the wrap cycle commits at the following wrap.
    n = 0;
    while (m_count != m_top && n < 50) begin step(); n++; end
    pulse_update();
    n = 0;
    while (commit_done !== 1'b1 && n < 100) begin step(); n++; end
    check("wrap_update_delay", n, 10);

    // update while armed is dropped.
    n = 0;
    while (m_count != 1 && n < 50) begin step(); n++; end
    cds = 0;
    pulse_update();
    repeat (3) begin step(); if (commit_done === 1'b1) cds++; end
    pulse_update();
    repeat (30) begin step(); if (commit_done === 1'b1) cds++; end
    check("armed_update_dropped", cds, 1);

`ifdef PWM_SOFT_START_EN
    // Soft start 0 -> 1000 at top=1023.
    write(0, 0); pulse_update(); wait_commit(100);
    write(NUM_CH, 1023); write(0, 1000); pulse_update();
    wraps = 0; cds = 0; n = 0;
    while (cds == 0 && n < 6000) begin
      step(); n++;
      if (period_start === 1'b1) wraps++;
      if (commit_done === 1'b1) cds++;
    end
    check("ramp_wraps", wraps, 4);
    repeat (1100) begin step(); if (commit_done === 1'b1) cds++; end
    check("ramp_commit_once", cds, 1);
`endif

    // Random traffic.
    repeat (3000) begin
      r = $urandom_range(0, 9);
      a = (r < 3) ? $urandom_range(0, NUM_CH) : $urandom_range(0, 15);
      wr_valid = (r < 5);
      wr_addr  = ADDR_W'(a);
      case ($urandom_range(0, 3))
        0:       wr_data = 16'd0;
        1:       wr_data = 16'hFFFF;
        2:       wr_data = 16'($urandom_range(0, 25));
        default: wr_data = 16'($urandom);
      endcase
      if (a == NUM_CH) wr_data = 16'($urandom_range(0, 20));
      update = ($urandom_range(0, 15) == 0);
      step();
    end
    wr_valid = 1'b0; update = 1'b0;

    // Reset in the middle of a commit.
    n = 0;
    while (m_mode != 0 && n < 20000) begin step(); n++; end
`ifdef PWM_SOFT_START_EN
    write(0, (m_act[0] > 30000) ? 0 : 60000);
    pulse_update();
    n = 0;
    while (m_mode != 2 && n < 2000) begin step(); n++; end
`else
    write(0, 77);
    pulse_update();
`endif
    check("busy_before_reset", busy, 1);
    reset_n = 1'b0;
    repeat (3) step();
    check("midreset_pwm", pwm_out, 4'hF);
    check("midreset_busy", busy, 0);
    check("midreset_ready", wr_ready, 1);
    reset_n = 1'b1;
    repeat (5) step();
    check("postreset_pwm", pwm_out, 4'hF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pwm_bank_controller.md
Name: pwm_bank_controller

Overview:
- Sequences a bank of NUM_CH PWM channels from one shared 16-bit period counter with a programmable period (top).
- Provides a valid/ready register-write port into shadow registers.
- Commits shadow values to the active compare set only at a period boundary, so every period is glitch-free.
- Sits between the host/bus logic and the board PWM pins. Outputs are active-low, the same convention as the single-channel PWM.

Parameters:
- NUM_CH, 4, number of PWM channels (1..15).
- ADDR_W, 4, write address width; must satisfy 2^ADDR_W > NUM_CH.
- TOP_DEFAULT, 16'hFFFF, period top loaded at reset.
- RAMP_STEP, 16'd256, per-period step size for soft start; unused unless PWM_SOFT_START_EN is defined.

Ports:
- clock  input  1  system clock; everything is on posedge.
- reset_n  input  1  synchronous, active-low reset.
- wr_valid  input  1  write request.
- wr_ready  output  1  controller can accept a write.
- wr_addr  input  ADDR_W  0..NUM_CH-1 selects a channel shadow; NUM_CH selects the top shadow.
- wr_data  input  16  value to write.
- update  input  1  single-cycle commit request.
- busy  output  1  high in any state other than IDLE.
- commit_done  output  1  one-cycle pulse when a commit completes.
- period_start  output  1  one-cycle pulse on the cycle the counter wraps to 0.
- pwm_out  output  NUM_CH  registered PWM outputs, active-low (1 = off).

Behaviour:
- Reset (reset_n=0 at posedge):
  - count=0; top and top shadow = TOP_DEFAULT.
  - All channel shadow and active values = 0.
  - State = IDLE; pwm_out = all 1s; wr_ready=1; busy=0; commit_done=0; period_start=0.
- Counter:
  - wrap = (count == top); count <= wrap ? 0 : count+1.
  - period_start <= wrap, so the pulse is high while count==0.
  - If top=0, count stays at 0 and period_start is high every cycle.
- Output:
  - pwm_out[i] <= ~(count < active[i]); latency is 1 clock from count.
  - active[i]=0 gives always 1 (0% duty). active[i] > top gives always 0 (100% duty).
  - Compare is unsigned 16-bit; count never exceeds top.
- Write handshake:
  - A transfer occurs when wr_valid && wr_ready. wr_ready is combinational: (state==IDLE).
  - The transfer writes the addressed shadow register on that edge.
  - Addresses greater than NUM_CH are accepted (handshake completes) and the data is discarded.
  - Writes do not affect active values or top until a commit.
- States:
  - IDLE: update=1 -> ARMED. A write transferred in the same cycle as update lands in the shadow first and is included in the commit.
  - ARMED: waits for wrap; update is ignored. wrap on the cycle of entering ARMED does not count; the wrap must occur while already in ARMED. On that wrap edge: top <= top shadow, active[i] <= shadow[i], state -> IDLE, commit_done <= 1.
  - RAMP: exists only with PWM_SOFT_START_EN; see Optional Feature.
- Commit timing: the new values and the new top govern the period that starts at count=0 immediately after the commit edge. There is no mixed period.
- update while busy is dropped, not queued.
- Reset mid-commit, in any state, returns to reset values; shadows are cleared.

Optional Feature:
- Macro: PWM_SOFT_START_EN.
- Defined:
  - At the ARMED wrap edge, top <= top shadow immediately.
  - Each active[i] moves toward shadow[i] by at most RAMP_STEP, saturating exactly at the target. Both up and down steps are allowed; no overshoot or underflow.
  - If every channel has reached its target -> IDLE with commit_done=1. Otherwise -> RAMP.
  - RAMP applies one further step per wrap until all channels reach target, then goes to IDLE and pulses commit_done on that edge.
  - In RAMP: wr_ready=0, busy=1, update ignored.
- Not defined: active values are copied directly; RAMP is unreachable and its logic is removed; RAMP_STEP is ignored.

Test Plan:
- Reset: hold reset_n=0 for 3 clocks -> pwm_out=all 1s, wr_ready=1, busy=0, count=0. After release, period_start first pulses after TOP_DEFAULT+1 clocks.
- Basic duty: write addr NUM_CH=9 and ch0=3, pulse update -> after the next wrap, commit_done pulses and period_start is every 10 clocks. pwm_out[0] is low for exactly 3 of each 10 clocks, beginning 1 clock after count=0.
- Boundary safety: with top=9, ch1=2 active, write ch1=7 and update at count=4 -> the current period still shows 2 low cycles; the next period shows 7. wr_ready=0 from update until the commit edge.
- Extremes: ch2=0, ch3=16'hFFFF, top=9 -> pwm_out[2] constant 1, pwm_out[3] constant 0. A write to addr 15 completes the handshake and changes nothing.
- Simultaneous events:
  - Write ch0=5 in the same cycle as update -> the committed value is 5.
  - update issued on the wrap cycle -> the commit occurs at the following wrap.
  - update while ARMED -> ignored.
- Soft start (PWM_SOFT_START_EN, RAMP_STEP=256, top=1023): ch0 goes 0 -> 1000 -> active values 256, 512, 768, 1000 on successive wraps; commit_done pulses once, on the 4th wrap. Asserting reset_n=0 during RAMP returns active to 0.
